// File: rtl/swu_pkg.sv
// Shared constants and helpers for the sliding window unit.
// The build macro SWU_POS_OUT_EN adds window position outputs to the top.
package swu_pkg;

    localparam int unsigned SWU_DATA_WIDTH      = 8;
    localparam int unsigned SWU_MAX_IMG_WIDTH   = 1920;
    localparam int unsigned SWU_MAX_KERNEL_SIZE = 7;
    localparam int unsigned SWU_WIN_ENTRIES     = SWU_MAX_KERNEL_SIZE * SWU_MAX_KERNEL_SIZE;
    localparam int unsigned SWU_CNT_W           = 12;

    typedef logic [SWU_CNT_W-1:0] swu_cnt_t;

    function automatic swu_cnt_t swu_clamp(input swu_cnt_t v, input swu_cnt_t lo, input swu_cnt_t hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/swu_line_buffer.sv
// Single-row delay line of programmable length: read-before-write RAM with a
// pointer wrapping at width-1, so dout_c is the sample written one row earlier.
module swu_line_buffer
    import swu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SWU_DATA_WIDTH,
    parameter int unsigned DEPTH      = SWU_MAX_IMG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  swu_cnt_t              width,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout_c
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     ptr_q;
    logic                  wrap_c;

    assign dout_c = mem[ptr_q];
    assign wrap_c = (ptr_q == ADDR_W'(width - SWU_CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= wrap_c ? '0 : ptr_q + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/sliding_window_unit.sv
// Streaming KxK window generator over raster-order pixels with K-1 line buffers.
// Define SWU_POS_OUT_EN to add fu_window_row_out/fu_window_col_out.
module sliding_window_unit
    import swu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = SWU_DATA_WIDTH,
    parameter int unsigned MAX_IMG_WIDTH   = SWU_MAX_IMG_WIDTH,
    parameter int unsigned MAX_KERNEL_SIZE = SWU_MAX_KERNEL_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            fu_kernel_size_in,
    input  logic [11:0]           fu_img_size_in,
    input  logic [DATA_WIDTH-1:0] fu_pixel_in,
    input  logic                  fu_pixel_valid_in,
    output logic [DATA_WIDTH-1:0] fu_window_out [MAX_KERNEL_SIZE*MAX_KERNEL_SIZE],
`ifdef SWU_POS_OUT_EN
    output logic                  fu_window_valid_out,
    output logic [11:0]           fu_window_row_out,
    output logic [11:0]           fu_window_col_out
`else
    output logic                  fu_window_valid_out
`endif
);

    localparam int unsigned MK    = MAX_KERNEL_SIZE;
    localparam int unsigned WIN   = MK * MK;
    localparam int unsigned NBUF  = MK - 1;
    localparam int unsigned IDX_W = $clog2(WIN);

    swu_cnt_t row_q, col_q, k_q, w_q;
    swu_cnt_t k_c, w_c;
    logic     frame_start_c, last_col_c, last_row_c, win_hit_c;
    int       kk;

    logic [DATA_WIDTH-1:0] tap_c [NBUF];
    logic [DATA_WIDTH-1:0] col_c [MK];
    logic [DATA_WIDTH-1:0] win_q [MK][MK];
    logic [DATA_WIDTH-1:0] win_d [MK][MK];
    logic [DATA_WIDTH-1:0] out_d [WIN];

    // Live config is only honoured on the first pixel of a frame, latched otherwise.
    always_comb begin
        frame_start_c = (row_q == '0) && (col_q == '0);
        k_c = frame_start_c ? swu_clamp(SWU_CNT_W'(fu_kernel_size_in), SWU_CNT_W'(1), SWU_CNT_W'(MK))
                            : k_q;
        w_c = frame_start_c ? swu_clamp(SWU_CNT_W'(fu_img_size_in), SWU_CNT_W'(1), SWU_CNT_W'(MAX_IMG_WIDTH))
                            : w_q;
        last_col_c = (col_q == w_c - SWU_CNT_W'(1));
        last_row_c = (row_q == w_c - SWU_CNT_W'(1));
        win_hit_c  = (row_q >= k_c - SWU_CNT_W'(1)) && (col_q >= k_c - SWU_CNT_W'(1));
        kk         = 32'(k_c);
    end

    for (genvar i = 0; i < NBUF; i++) begin : g_lb
        logic [DATA_WIDTH-1:0] din;
        if (i == 0) begin : g_head
            assign din = fu_pixel_in;
        end else begin : g_chain
            assign din = tap_c[i-1];
        end
        swu_line_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (MAX_IMG_WIDTH)
        ) u_lb (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (fu_pixel_valid_in),
            .width (w_c),
            .din   (din),
            .dout_c(tap_c[i])
        );
    end

    // New right column: oldest buffer tap on top, live pixel at row K-1.
    always_comb begin
        for (int r = 0; r < MK; r++) begin
            col_c[r] = '0;
            if (r == kk - 1) col_c[r] = fu_pixel_in;
            for (int j = 0; j < NBUF; j++) begin
                if (r + j == kk - 2) col_c[r] = tap_c[j];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < MK; r++) begin
            for (int c = 0; c < MK; c++) win_d[r][c] = '0;
            for (int c = 0; c < MK - 1; c++) begin
                if (c < kk - 1) win_d[r][c] = win_q[r][c+1];
            end
            for (int c = 0; c < MK; c++) begin
                if (c == kk - 1) win_d[r][c] = col_c[r];
            end
        end
    end

    // Pack the active KxK region row-major; unused tail entries stay zero.
    always_comb begin
        for (int i = 0; i < WIN; i++) out_d[i] = '0;
        for (int r = 0; r < MK; r++) begin
            for (int c = 0; c < MK; c++) begin
                if (r < kk && c < kk) out_d[IDX_W'(r * kk + c)] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_q               <= '0;
            col_q               <= '0;
            k_q                 <= SWU_CNT_W'(1);
            w_q                 <= SWU_CNT_W'(1);
            fu_window_valid_out <= 1'b0;
            for (int r = 0; r < MK; r++) begin
                for (int c = 0; c < MK; c++) win_q[r][c] <= '0;
            end
            for (int i = 0; i < WIN; i++) fu_window_out[i] <= '0;
        end else begin
            fu_window_valid_out <= 1'b0;
            if (fu_pixel_valid_in) begin
                k_q                 <= k_c;
                w_q                 <= w_c;
                col_q               <= last_col_c ? '0 : col_q + SWU_CNT_W'(1);
                if (last_col_c) begin
                    row_q <= last_row_c ? '0 : row_q + SWU_CNT_W'(1);
                end
                win_q               <= win_d;
                fu_window_out       <= out_d;
                fu_window_valid_out <= win_hit_c;
            end
        end
    end

`ifdef SWU_POS_OUT_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            fu_window_row_out <= '0;
            fu_window_col_out <= '0;
        end else if (fu_pixel_valid_in) begin
            fu_window_row_out <= row_q;
            fu_window_col_out <= col_q;
        end
    end
`endif

endmodule

// File: tb/tb_sliding_window_unit.sv
// Scoreboard bench for sliding_window_unit: a reference image model predicts each
// window when a pixel is driven; the monitor compares on every output valid.
module tb_sliding_window_unit;

    localparam int DW  = 8;
    localparam int MK  = 7;
    localparam int WIN = MK * MK;

    typedef struct {
        logic [511:0] win;
        logic [11:0]  row;
        logic [11:0]  col;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [2:0]    fu_kernel_size_in;
    logic [11:0]   fu_img_size_in;
    logic [DW-1:0] fu_pixel_in;
    logic          fu_pixel_valid_in;
    logic [DW-1:0] fu_window_out [WIN];
    logic          fu_window_valid_out;
`ifdef SWU_POS_OUT_EN
    logic [11:0]   fu_window_row_out;
    logic [11:0]   fu_window_col_out;
`endif

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_valid = 0;
    int         exp_total = 0;
    logic [7:0] fr [0:4095];

    sliding_window_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fu_kernel_size_in  (fu_kernel_size_in),
        .fu_img_size_in     (fu_img_size_in),
        .fu_pixel_in        (fu_pixel_in),
        .fu_pixel_valid_in  (fu_pixel_valid_in),
        .fu_window_out      (fu_window_out),
`ifdef SWU_POS_OUT_EN
        .fu_window_valid_out(fu_window_valid_out),
        .fu_window_row_out  (fu_window_row_out),
        .fu_window_col_out  (fu_window_col_out)
`else
        .fu_window_valid_out(fu_window_valid_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] pack_out();
        logic [511:0] v = '0;
        for (int i = 0; i < WIN; i++) v[i*8 +: 8] = fu_window_out[i];
        return v;
    endfunction

    function automatic logic [511:0] exp_win(input int row, input int col, input int k, input int w);
        logic [511:0] e = '0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                e[(r*k+c)*8 +: 8] = fr[(row - k + 1 + r) * w + (col - k + 1 + c)];
            end
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [7:0] p);
        @(negedge clk);
        fu_pixel_valid_in = v;
        fu_pixel_in       = p;
    endtask

    // Drive npix pixels of a w x w frame; tail adds idle cycles and checks the valid total.
    task automatic run_frame(input int k_in, input int w, input int npix, input bit bubbles, input bit tail);
        int k;
        int r;
        int c;
        exp_t e;
        k = (k_in == 0) ? 1 : k_in;
        fu_kernel_size_in = 3'(k_in);
        fu_img_size_in    = 12'(w);
        if (npix == w * w) exp_total += (w >= k) ? (w - k + 1) * (w - k + 1) : 0;
        for (int i = 0; i < npix; i++) begin
            r = i / w;
            c = i % w;
            fr[i] = 8'(i + 1);
            if (r >= k - 1 && c >= k - 1) begin
                e.win = exp_win(r, c, k, w);
                e.row = 12'(r);
                e.col = 12'(c);
                sb.push_back(e);
                if (npix != w * w) exp_total++;
            end
            drive(1'b1, 8'(i + 1));
            if (bubbles) drive(1'b0, 8'hA5);
        end
        if (tail) begin
            drive(1'b0, 8'h00);
            drive(1'b0, 8'h00);
            drive(1'b0, 8'h00);
            check_eq("valid_count", 512'(n_valid), 512'(exp_total));
            check_eq("sb_drained", 512'(sb.size()), 512'(0));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n && fu_window_valid_out) begin
            n_valid++;
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 512'(1), 512'(0));
            end else begin
                mon_e = sb.pop_front();
                check_eq("window", pack_out(), mon_e.win);
`ifdef SWU_POS_OUT_EN
                check_eq("win_row", 512'(fu_window_row_out), 512'(mon_e.row));
                check_eq("win_col", 512'(fu_window_col_out), 512'(mon_e.col));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n             = 1'b1;
        fu_kernel_size_in = 3'd3;
        fu_img_size_in    = 12'd6;
        fu_pixel_in       = '0;
        fu_pixel_valid_in = 1'b0;
        repeat (3) drive(1'b0, 8'h00);
        check_eq("rst_valid", 512'(fu_window_valid_out), 512'(0));
        check_eq("rst_window", pack_out(), 512'(0));
`ifdef SWU_POS_OUT_EN
        check_eq("rst_row", 512'(fu_window_row_out), 512'(0));
        check_eq("rst_col", 512'(fu_window_col_out), 512'(0));
`endif
        @(negedge clk);
        rst_n = 1'b0;

        run_frame(3, 6, 36, 1'b0, 1'b0);   // flows straight into the next frame
        run_frame(5, 8, 64, 1'b0, 1'b1);
        run_frame(2, 4, 16, 1'b0, 1'b1);
        run_frame(3, 6, 36, 1'b1, 1'b1);
        run_frame(0, 3, 9, 1'b0, 1'b1);
        run_frame(3, 2, 4, 1'b0, 1'b1);

        // Abort a frame after pixel 20, then restart cleanly.
        run_frame(3, 6, 20, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        fu_pixel_valid_in = 1'b1;
        fu_pixel_in       = 8'h77;
        repeat (2) @(negedge clk);
        check_eq("midrst_valid", 512'(fu_window_valid_out), 512'(0));
        check_eq("midrst_window", pack_out(), 512'(0));
        fu_pixel_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        run_frame(3, 6, 36, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
